poly_sched: RTL and testbench

- Controller and scheduler for poly_core, the POKEY 4/5/9/17-bit polynomial counter block.
- Sequences poly_core's init and 9/17-bit select from SKCTL/AUDCTL state, aligned to the 1.79 MHz enable.
- Serves CPU RANDOM reads via a req/ack handshake.
- Applies per-channel AUDC distortion selection to the four audio channels' divider underflow ticks, producing the raw channel square/noise outputs.

---
 rtl/poly_sched_if.sv | 9 +
 rtl/poly_sched.sv | 163 ++++++++++++++++
 tb/tb_poly_sched.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/poly_sched_if.sv
// RANDOM read handshake between the CPU bus side and poly_sched.
interface poly_sched_if;
    logic       rd_req;
    logic       rd_ack;
    logic [7:0] rd_data;

    modport master (output rd_req, input rd_ack, input rd_data);
    modport slave  (input rd_req, output rd_ack, output rd_data);
endinterface

// File: rtl/poly_sched.sv
// POKEY poly-counter scheduler: init/9-17 select sequencing, RANDOM reads,
// and per-channel AUDC distortion selection on divider underflow ticks.

module poly_sched_ch (
    input  logic       clk,
    input  logic       reset,
    input  logic       poly_init_i,
    input  logic       volonly_i,
    input  logic       tick_i,
    input  logic [2:0] dist_i,
    input  logic       poly4_i,
    input  logic       poly5_i,
    input  logic       poly917_i,
    output logic       ch_o
);
    logic ch_q, ch_d;
    logic gate;

    assign gate = dist_i[2] | poly5_i;

    // Volume-only forcing outranks the init blanking.
    always_comb begin
        ch_d = ch_q;
        if (volonly_i) begin
            ch_d = 1'b1;
        end else if (poly_init_i) begin
            ch_d = 1'b0;
        end else if (tick_i && gate) begin
            if (dist_i[0])      ch_d = ~ch_q;
            else if (dist_i[1]) ch_d = poly4_i;
            else                ch_d = poly917_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ch_q <= 1'b0;
        else       ch_q <= ch_d;
    end

    assign ch_o = ch_q;
endmodule

module poly_sched #(
    parameter int INIT_HOLD = 4,
    parameter int NUM_CH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en179,
    input  logic [1:0]          skctl_init,
    input  logic                audctl_poly9,
    input  logic [3*NUM_CH-1:0] audc_dist,
    input  logic [NUM_CH-1:0]   audc_volonly,
    input  logic [NUM_CH-1:0]   ch_tick,
    input  logic [7:0]          rnd_num,
    input  logic                poly4,
    input  logic                poly5,
    input  logic                poly917,
    output logic                poly_init,
    output logic                sel9bit,
    poly_sched_if.slave         rd_if,
    output logic [NUM_CH-1:0]   ch_out
);
    localparam logic [3:0] HOLD_LD = 4'(INIT_HOLD);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       poly_init_q;
    logic       sel9_q, sel9_d;
    logic       ack_q, ack_d;
    logic [7:0] data_q, data_d;
    logic       skctl_go;

    assign skctl_go = (skctl_init != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HOLD;
            cnt_q       <= HOLD_LD;
            poly_init_q <= 1'b1;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (en179) begin
                        if (cnt_q == 4'd1) begin
                            state_q     <= skctl_go ? S_RUN : S_INIT;
                            poly_init_q <= ~skctl_go;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                S_INIT: begin
                    // Leave init only on a slow-clock edge.
                    if (en179 && skctl_go) begin
                        state_q     <= S_RUN;
                        poly_init_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!skctl_go) begin
                        state_q     <= S_INIT;
                        poly_init_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_HOLD;
                    cnt_q       <= HOLD_LD;
                    poly_init_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        sel9_d = en179 ? audctl_poly9 : sel9_q;
        ack_d  = 1'b0;
        data_d = data_q;
        // The idle cycle after each ack makes a held request ack every other clk.
        if (rd_if.rd_req && !ack_q) begin
            ack_d  = 1'b1;
            data_d = poly_init_q ? 8'hFF : rnd_num;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel9_q <= 1'b0;
            ack_q  <= 1'b0;
            data_q <= 8'h00;
        end else begin
            sel9_q <= sel9_d;
            ack_q  <= ack_d;
            data_q <= data_d;
        end
    end

    assign poly_init     = poly_init_q;
    assign sel9bit       = sel9_q;
    assign rd_if.rd_ack  = ack_q;
    assign rd_if.rd_data = data_q;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        poly_sched_ch u_ch (
            .clk         (clk),
            .reset       (reset),
            .poly_init_i (poly_init_q),
            .volonly_i   (audc_volonly[n]),
            .tick_i      (ch_tick[n]),
            .dist_i      (audc_dist[3*n +: 3]),
            .poly4_i     (poly4),
            .poly5_i     (poly5),
            .poly917_i   (poly917),
            .ch_o        (ch_out[n])
        );
    end
endmodule

// File: tb/tb_poly_sched.sv
// Directed bench for poly_sched: FSM sequencing, sel9bit, RANDOM reads, channels.
module tb_poly_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic        en179;
    logic [1:0]  skctl_init;
    logic        audctl_poly9;
    logic [11:0] audc_dist;
    logic [3:0]  audc_volonly;
    logic [3:0]  ch_tick;
    logic [7:0]  rnd_num;
    logic        poly4, poly5, poly917;
    logic        poly_init, sel9bit;
    logic [3:0]  ch_out;

    int errors = 0;
    int checks = 0;
    int acks;

    poly_sched_if rd_if ();

    poly_sched #(.INIT_HOLD(4), .NUM_CH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .en179        (en179),
        .skctl_init   (skctl_init),
        .audctl_poly9 (audctl_poly9),
        .audc_dist    (audc_dist),
        .audc_volonly (audc_volonly),
        .ch_tick      (ch_tick),
        .rnd_num      (rnd_num),
        .poly4        (poly4),
        .poly5        (poly5),
        .poly917      (poly917),
        .poly_init    (poly_init),
        .sel9bit      (sel9bit),
        .rd_if        (rd_if.slave),
        .ch_out       (ch_out)
    );

    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic en_pulse();
        en179 = 1'b1;
        step();
        en179 = 1'b0;
    endtask

    task automatic tick(input logic [3:0] mask);
        en179   = 1'b1;
        ch_tick = mask;
        step();
        en179   = 1'b0;
        ch_tick = 4'b0000;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; en179 = 1'b1; skctl_init = 2'b11; audctl_poly9 = 1'b0;
        audc_dist = 12'h000; audc_volonly = 4'h0; ch_tick = 4'h0;
        rnd_num = 8'h00; poly4 = 1'b0; poly5 = 1'b0; poly917 = 1'b0;
        rd_if.rd_req = 1'b0;
        idle(3);
        chk("rst_poly_init", 32'(poly_init), 32'd1);
        chk("rst_sel9bit", 32'(sel9bit), 32'd0);
        chk("rst_rd_ack", 32'(rd_if.rd_ack), 32'd0);
        chk("rst_rd_data", 32'(rd_if.rd_data), 32'h00);
        chk("rst_ch_out", 32'(ch_out), 32'h0);

        // Hold for 4 enables after reset release.
        reset = 1'b0; en179 = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            idle(2);
            en_pulse();
            chk($sformatf("hold_pulse%0d", p), 32'(poly_init), 32'd1);
        end
        idle(2);
        chk("hold_pre4", 32'(poly_init), 32'd1);
        en_pulse();
        chk("hold_pulse4_run", 32'(poly_init), 32'd0);

        // RUN -> INIT immediately, INIT -> RUN only on en179.
        idle(1);
        skctl_init = 2'b00;
        step();
        chk("run_to_init", 32'(poly_init), 32'd1);
        skctl_init = 2'b11;
        idle(2);
        chk("init_wait_en", 32'(poly_init), 32'd1);
        en_pulse();
        chk("init_to_run", 32'(poly_init), 32'd0);

        // RANDOM read in RUN.
        rnd_num = 8'h5A; rd_if.rd_req = 1'b1;
        step();
        chk("rd_run_ack", 32'(rd_if.rd_ack), 32'd1);
        chk("rd_run_data", 32'(rd_if.rd_data), 32'h5A);
        rd_if.rd_req = 1'b0; rnd_num = 8'h11;
        step();
        chk("rd_ack_drop", 32'(rd_if.rd_ack), 32'd0);
        chk("rd_data_held", 32'(rd_if.rd_data), 32'h5A);

        // RANDOM read during INIT returns FF.
        skctl_init = 2'b00;
        step();
        rnd_num = 8'h33; rd_if.rd_req = 1'b1;
        step();
        chk("rd_init_ack", 32'(rd_if.rd_ack), 32'd1);
        chk("rd_init_data", 32'(rd_if.rd_data), 32'hFF);
        rd_if.rd_req = 1'b0;
        step();

        // Held request over 4 clks yields 2 acks.
        acks = 0;
        rd_if.rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rd_if.rd_ack) acks++;
        end
        rd_if.rd_req = 1'b0;
        chk("rd_held_acks", 32'(acks), 32'd2);
        skctl_init = 2'b11;
        en_pulse();
        chk("back_to_run", 32'(poly_init), 32'd0);

        // sel9bit follows AUDCTL only on en179.
        audctl_poly9 = 1'b1;
        step();
        chk("sel9_wait", 32'(sel9bit), 32'd0);
        en_pulse();
        chk("sel9_set", 32'(sel9bit), 32'd1);
        audctl_poly9 = 1'b0;
        step();
        chk("sel9_hold", 32'(sel9bit), 32'd1);
        en_pulse();
        chk("sel9_clr", 32'(sel9bit), 32'd0);

        // ch3=100 ch2=110 ch1=001 ch0=101
        audc_dist = {3'b100, 3'b110, 3'b001, 3'b101};
        poly5 = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick(4'b0001);
            chk($sformatf("ch0_tone%0d", t), 32'(ch_out[0]), 32'((t % 2) == 0));
        end

        poly5 = 1'b1; tick(4'b0010); chk("ch1_t1", 32'(ch_out[1]), 32'd1);
        poly5 = 1'b0; tick(4'b0010); chk("ch1_t2_hold", 32'(ch_out[1]), 32'd1);
        poly5 = 1'b1; tick(4'b0010); chk("ch1_t3", 32'(ch_out[1]), 32'd0);
        poly5 = 1'b0; tick(4'b0010); chk("ch1_t4_hold", 32'(ch_out[1]), 32'd0);

        poly4 = 1'b1; tick(4'b0100); chk("ch2_poly4_1", 32'(ch_out[2]), 32'd1);
        poly4 = 1'b0; tick(4'b0100); chk("ch2_poly4_0", 32'(ch_out[2]), 32'd0);

        poly5 = 1'b0; poly917 = 1'b1; tick(4'b1000); chk("ch3_p917_1", 32'(ch_out[3]), 32'd1);
        poly5 = 1'b1; poly917 = 1'b0; tick(4'b1000); chk("ch3_p917_0", 32'(ch_out[3]), 32'd0);

        // All four at once: ch0 toggles, ch1 gated off, ch2/ch3 load poly bits.
        poly5 = 1'b0; poly4 = 1'b1; poly917 = 1'b1;
        tick(4'b1111);
        chk("all_ticks", 32'(ch_out), 32'hD);

        audc_volonly = 4'b0010;
        step();
        chk("volonly_force", 32'(ch_out), 32'hF);
        audc_volonly = 4'b0000;
        step();
        chk("volonly_left", 32'(ch_out), 32'hF);

        // Reset dominates a coincident enable and ticks.
        reset = 1'b1; en179 = 1'b1; ch_tick = 4'hF;
        step();
        chk("reset_ch_out", 32'(ch_out), 32'h0);
        chk("reset_poly_init", 32'(poly_init), 32'd1);
        reset = 1'b0; en179 = 1'b0; ch_tick = 4'h0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
